// File: rtl/retro_sram_timed.sv
// Registered-strobe controller that bridges a Ready/DataReady initiator port to one or more
// asynchronous SRAM devices, with configurable read/write wait states and read-to-write turnaround.
module retro_sram_timed #(
    parameter int AddressBusWidth  = 16,
    parameter int DataBusWidth     = 1,
    parameter int ChipCount        = 1,
    parameter int ReadWaitStates   = 1,
    parameter int WriteWaitStates  = 1,
    parameter int TurnaroundCycles = 1,
    localparam int CS = (ChipCount > 1) ? $clog2(ChipCount) : 0
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             Access,
    input  logic                             Write,
    input  logic [AddressBusWidth-1:0]       Address,
    input  logic [DataBusWidth-1:0]          ByteEnable,
    input  logic [8*DataBusWidth-1:0]        Din,
    output logic [8*DataBusWidth-1:0]        Dout,
    output logic                             Ready,
    output logic                             DataReady,
    output logic [AddressBusWidth-CS-1:0]    SramAddress,
    output logic [ChipCount-1:0]             SramCE_n,
    output logic                             SramOE_n,
    output logic                             SramWE_n,
    output logic [DataBusWidth-1:0]          SramBE_n,
    output logic [8*DataBusWidth-1:0]        SramDout,
    output logic                             SramDrive,
    input  logic [8*DataBusWidth-1:0]        SramDin
);

    localparam int DW  = 8 * DataBusWidth;
    localparam int SAW = AddressBusWidth - CS;
    localparam int IW  = (CS > 0) ? CS : 1;

    localparam logic [3:0] R_LOAD = 4'(ReadWaitStates);
    localparam logic [3:0] W_LOAD = 4'(WriteWaitStates);
    localparam logic [3:0] T_LOAD = 4'((TurnaroundCycles > 0) ? TurnaroundCycles - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        READ,
        WRITE,
        HOLD
    } state_t;

    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       last_read, last_read_n;

    logic [AddressBusWidth-1:0] addr_q;
    logic [DataBusWidth-1:0]    be_q;

    logic                       accept;
    logic [AddressBusWidth-1:0] req_addr;
    logic [DataBusWidth-1:0]    req_be;
    logic [IW-1:0]              req_idx;
    logic [ChipCount-1:0]       req_ce_n;
    logic                       req_in_range;

    logic [ChipCount-1:0]    ce_n_n;
    logic                    oe_n_n, we_n_n, drive_n, dready_n;
    logic [DataBusWidth-1:0] be_n_n;
    logic [DW-1:0]           dout_n, sram_dout_n;
    logic [SAW-1:0]          sram_addr_n;

    assign Ready  = (state == IDLE) && !Reset;
    assign accept = Access && Ready;

    // The request being set up on this edge: live inputs on accept, the held copy afterwards.
    assign req_addr = accept ? Address : addr_q;
    assign req_be   = accept ? ByteEnable : be_q;

    generate
        if (CS > 0) begin : g_decode
            assign req_idx = req_addr[AddressBusWidth-1 -: CS];
        end else begin : g_single
            assign req_idx = '0;
        end
    endgenerate

    // An index with no matching device leaves every chip enable high.
    always_comb begin
        req_ce_n = '1;
        for (int i = 0; i < ChipCount; i++) begin
            if (req_idx == IW'(i)) req_ce_n[i] = 1'b0;
        end
    end

    assign req_in_range = ~&req_ce_n;

    // NOTE: request holding registers carry no reset; they are always written on accept before use.
    always_ff @(posedge Clk) begin
        if (accept) begin
            addr_q <= Address;
            be_q   <= ByteEnable;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n     = state;
        cnt_n       = cnt;
        last_read_n = last_read;
        dready_n    = 1'b0;
        dout_n      = Dout;
        sram_addr_n = accept ? Address[SAW-1:0] : SramAddress;
        sram_dout_n = SramDout;
        ce_n_n      = '1;
        oe_n_n      = 1'b1;
        we_n_n      = 1'b1;
        be_n_n      = '1;
        drive_n     = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (!Write) begin
                        state_n = READ;
                        cnt_n   = R_LOAD;
                    end else begin
                        last_read_n = 1'b0;
                        sram_dout_n = Din;
                        if (last_read && (TurnaroundCycles > 0)) begin
                            state_n = TURN;
                            cnt_n   = T_LOAD;
                        end else begin
                            state_n = WRITE;
                            cnt_n   = W_LOAD;
                        end
                    end
                end
            end
            TURN: begin
                if (cnt == 4'd0) begin
                    state_n = WRITE;
                    cnt_n   = W_LOAD;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            READ: begin
                if (cnt == 4'd0) begin
                    state_n     = IDLE;
                    dready_n    = 1'b1;
                    last_read_n = 1'b1;
                    dout_n      = req_in_range ? SramDin : '1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            WRITE: begin
                if (cnt == 4'd0) state_n = HOLD;
                else             cnt_n   = cnt - 4'd1;
            end
            HOLD:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Strobes are a function of the state being entered, so they land in registers.
        case (state_n)
            READ: begin
                ce_n_n = req_ce_n;
                oe_n_n = 1'b0;
                be_n_n = '0;
            end
            WRITE: begin
                ce_n_n  = req_ce_n;
                we_n_n  = 1'b0;
                be_n_n  = ~req_be;
                drive_n = 1'b1;
            end
            HOLD: begin
                ce_n_n  = req_ce_n;
                be_n_n  = ~req_be;
                drive_n = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            last_read   <= 1'b0;
            DataReady   <= 1'b0;
            Dout        <= '0;
            SramAddress <= '0;
            SramDout    <= '0;
            SramCE_n    <= '1;
            SramOE_n    <= 1'b1;
            SramWE_n    <= 1'b1;
            SramBE_n    <= '1;
            SramDrive   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            last_read   <= last_read_n;
            DataReady   <= dready_n;
            Dout        <= dout_n;
            SramAddress <= sram_addr_n;
            SramDout    <= sram_dout_n;
            SramCE_n    <= ce_n_n;
            SramOE_n    <= oe_n_n;
            SramWE_n    <= we_n_n;
            SramBE_n    <= be_n_n;
            SramDrive   <= drive_n;
        end
    end

endmodule

// File: tb/tb_retro_sram_timed.sv
// Directed bench for retro_sram_timed: a vector table walked cycle by cycle against a small
// timing model, plus hand sequences for held Access and reset during a read.
module tb_retro_sram_timed;

    localparam int AW = 16;
    localparam int DB = 2;
    localparam int NC = 3;
    localparam int R  = 1;
    localparam int W  = 2;
    localparam int T  = 2;

    logic        Clk = 1'b0;
    logic        Reset, Access, Write;
    logic [15:0] Address;
    logic [1:0]  ByteEnable;
    logic [15:0] Din, Dout, SramDout, SramDin;
    logic        Ready, DataReady, SramOE_n, SramWE_n, SramDrive;
    logic [13:0] SramAddress;
    logic [2:0]  SramCE_n;
    logic [1:0]  SramBE_n;

    retro_sram_timed #(
        .AddressBusWidth(AW), .DataBusWidth(DB), .ChipCount(NC),
        .ReadWaitStates(R), .WriteWaitStates(W), .TurnaroundCycles(T)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Access(Access), .Write(Write),
        .Address(Address), .ByteEnable(ByteEnable), .Din(Din), .Dout(Dout),
        .Ready(Ready), .DataReady(DataReady), .SramAddress(SramAddress),
        .SramCE_n(SramCE_n), .SramOE_n(SramOE_n), .SramWE_n(SramWE_n),
        .SramBE_n(SramBE_n), .SramDout(SramDout), .SramDrive(SramDrive),
        .SramDin(SramDin)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] din;
        logic [15:0] sdin;
        logic [2:0]  ce;
        logic [15:0] dout;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic        tb_last_read = 1'b0;
    logic [15:0] tb_dout = 16'h0000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] strobes();
        return {SramCE_n, SramOE_n, SramWE_n, SramBE_n, SramDrive, Ready, DataReady};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!Ready && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        check("ready_timeout", 64'(Ready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int turn, active, total;
        logic [2:0] ece;
        logic       eoe, ewe, edrv, erdy, edr;
        logic [1:0] ebe;
        turn   = (v.wr && tb_last_read) ? T : 0;
        active = v.wr ? W + 1 : R + 1;
        total  = turn + active + (v.wr ? 1 : 0) + 1;
        wait_ready();
        Access = 1'b1; Write = v.wr; Address = v.addr;
        ByteEnable = v.be; Din = v.din; SramDin = v.sdin;
        @(posedge Clk); #1;
        Access = 1'b0;
        for (int c = 1; c <= total; c++) begin
            ece = 3'b111; eoe = 1'b1; ewe = 1'b1; ebe = 2'b11;
            edrv = 1'b0; erdy = 1'b0; edr = 1'b0;
            if (c <= turn) begin
                // turnaround: everything inactive
            end else if (c <= turn + active) begin
                ece = v.ce;
                if (v.wr) begin
                    ewe = 1'b0; ebe = ~v.be; edrv = 1'b1;
                    check($sformatf("v%0d_sram_dout_c%0d", idx, c), 64'(SramDout), 64'(v.din));
                end else begin
                    eoe = 1'b0; ebe = 2'b00;
                end
                check($sformatf("v%0d_sram_addr_c%0d", idx, c), 64'(SramAddress), 64'(v.addr[13:0]));
            end else if (v.wr && c == turn + active + 1) begin
                ece = v.ce; ebe = ~v.be; edrv = 1'b1;
            end else begin
                erdy = 1'b1; edr = !v.wr;
                if (!v.wr) tb_dout = v.dout;
                check($sformatf("v%0d_dout", idx), 64'(Dout), 64'(tb_dout));
            end
            check($sformatf("v%0d_strobes_c%0d", idx, c), 64'(strobes()),
                  64'({ece, eoe, ewe, ebe, edrv, erdy, edr}));
            if (c < total) begin
                @(posedge Clk); #1;
            end
        end
        tb_last_read = !v.wr;
    endtask

    vec_t vecs[8];

    initial begin
        int dr_count, oe_falls;
        logic oe_prev;

        vecs[0] = '{1'b0, 16'h0010, 2'b00, 16'h0000, 16'h00A5, 3'b110, 16'h00A5};
        vecs[1] = '{1'b0, 16'h8020, 2'b00, 16'h0000, 16'hBEEF, 3'b011, 16'hBEEF};
        vecs[2] = '{1'b1, 16'h0004, 2'b10, 16'h1234, 16'h0000, 3'b110, 16'h0000};
        vecs[3] = '{1'b1, 16'h4008, 2'b11, 16'hCAFE, 16'h0000, 3'b101, 16'h0000};
        vecs[4] = '{1'b1, 16'h0005, 2'b00, 16'h5555, 16'h0000, 3'b110, 16'h0000};
        vecs[5] = '{1'b0, 16'hC010, 2'b00, 16'h0000, 16'h1357, 3'b111, 16'hFFFF};
        vecs[6] = '{1'b1, 16'hC011, 2'b11, 16'hAAAA, 16'h0000, 3'b111, 16'h0000};
        vecs[7] = '{1'b0, 16'h3FFF, 2'b00, 16'h0000, 16'h0F0F, 3'b110, 16'h0F0F};

        Reset = 1'b1; Access = 1'b0; Write = 1'b0; Address = '0;
        ByteEnable = '0; Din = '0; SramDin = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_strobes", 64'(strobes()), 64'({3'b111, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0}));
        check("reset_dout", 64'(Dout), 64'd0);
        check("reset_sram_addr", 64'(SramAddress), 64'd0);
        check("reset_sram_dout", 64'(SramDout), 64'd0);
        Reset = 1'b0;
        #1;
        check("ready_after_reset", 64'(Ready), 64'd1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Access held high across busy cycles: one read per R+2 cycles, no duplicates.
        wait_ready();
        Access = 1'b1; Write = 1'b0; Address = 16'h0010; SramDin = 16'h6789;
        dr_count = 0; oe_falls = 0; oe_prev = SramOE_n;
        for (int k = 1; k <= 4 * (R + 2); k++) begin
            @(posedge Clk); #1;
            if (DataReady) dr_count++;
            if (oe_prev && !SramOE_n) oe_falls++;
            oe_prev = SramOE_n;
        end
        Access = 1'b0;
        tb_last_read = 1'b1;
        tb_dout = 16'h6789;
        check("held_access_dataready", 64'(dr_count), 64'd4);
        check("held_access_oe_falls", 64'(oe_falls), 64'd4);
        check("held_access_dout", 64'(Dout), 64'(tb_dout));

        // Reset during the second READ cycle aborts the read.
        wait_ready();
        Access = 1'b1; Write = 1'b0; Address = 16'h0020; SramDin = 16'h1111;
        @(posedge Clk); #1;
        Access = 1'b0;
        check("abort_read_c1", 64'(strobes()), 64'({3'b110, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0}));
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        check("abort_strobes", 64'(strobes()), 64'({3'b111, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0}));
        check("abort_dout", 64'(Dout), 64'd0);
        tb_dout = 16'h0000;
        Reset = 1'b0;
        #1;
        check("abort_ready_release", 64'(Ready), 64'd1);
        @(posedge Clk); #1;
        check("abort_no_dataready", 64'(DataReady), 64'd0);
        tb_last_read = 1'b0;

        // After reset there is no previous read, so this write must skip TURN.
        run_vec(vecs[3], 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
